// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
// Purpose : Shared defaults and FSM state encoding for the CPU output-port
//           capture block, plus a small saturating-increment helper used by
//           the drop counter.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package io_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 8;

    // State encoding kept as plain constants so older tools and waveform
    // viewers see stable numeric values.
    typedef logic [1:0] state_t;

    localparam state_t ST_DISABLED = 2'd0;
    localparam state_t ST_PRIME    = 2'd1;
    localparam state_t ST_TRACK    = 2'd2;

    // Increment an 8-bit counter but stick at 255 instead of wrapping.
    function automatic logic [7:0] satInc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Purpose : Single-clock FIFO holding captured words. A push while full is
//           only accepted when a pop happens in the same cycle; a pop while
//           empty is ignored. The head word is shown combinationally and
//           reads as zero when the FIFO is empty.
// Ports   : clk      - clock
//           rst      - synchronous active-high reset, empties the FIFO
//           i_push   - request to write i_data
//           i_pop    - request to remove the head entry
//           i_data   - word to write
//           o_data   - head word (zero when empty)
//           o_full   - FIFO holds DEPTH entries
//           o_empty  - FIFO holds no entries
//           o_count  - number of entries held (0..DEPTH)
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [DATA_W-1:0]        i_data,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wrPtr;
    logic [AW-1:0]     r_rdPtr;
    logic [AW:0]       r_count;

    logic w_popOk;
    logic w_pushOk;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = o_empty ? '0 : r_mem[r_rdPtr];

    // A full FIFO can still take a word when the head leaves in the same
    // cycle, because the freed slot is the one being written.
    assign w_popOk  = i_pop && !o_empty;
    assign w_pushOk = i_push && (!o_full || w_popOk);

    // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the
    // pointers wrap naturally at their bit width and the extra count bit
    // separates full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_pushOk) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_popOk) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_pushOk, w_popOk})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset since the head is masked to
    // zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_pushOk) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

endmodule

// File: rtl/out_port_capture.sv
// -----------------------------------------------------------------------------
// out_port_capture
// Purpose : Watches a CPU output port and queues each new value it takes.
//           The port is registered first; after enable the first registered
//           value is always captured, then only changes are captured.
//           Captures that find the FIFO full are dropped and counted.
// Ports   : clk       - clock
//           rst       - synchronous active-high reset
//           en        - capture enable
//           out_port  - monitored CPU output port
//           clr_ovf   - pulse clearing overflow and drop_cnt
//           cap_data  - oldest captured word (zero when empty)
//           cap_valid - cap_data holds an entry
//           cap_ready - consumer takes the head entry
//           count     - entries currently held
//           overflow  - sticky: at least one capture was dropped
//           drop_cnt  - dropped captures, saturating at 255
// -----------------------------------------------------------------------------
module out_port_capture
    import io_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [DATA_W-1:0]        out_port,
    input  logic                     clr_ovf,
    output logic [DATA_W-1:0]        cap_data,
    output logic                     cap_valid,
    input  logic                     cap_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    logic [DATA_W-1:0]      r_sq;
    logic [DATA_W-1:0]      r_lastQ;
    state_t                 r_state;
    logic                   r_overflow;
    logic [7:0]             r_dropCnt;

    state_t                 w_nextState;
    logic                   w_capture;
    logic                   w_pop;
    logic                   w_drop;
    logic                   w_fifoFull;
    logic                   w_fifoEmpty;
    logic [$clog2(DEPTH):0] w_fifoCount;
    logic [DATA_W-1:0]      w_headData;

    // PRIME takes the sample unconditionally; TRACK only on a change.
    assign w_capture = en && ((r_state == ST_PRIME) ||
                              ((r_state == ST_TRACK) && (r_sq != r_lastQ)));
    assign w_pop     = cap_ready && !w_fifoEmpty;
    assign w_drop    = w_capture && w_fifoFull && !w_pop;

    // Dropping enable always parks the FSM; otherwise walk through PRIME
    // into TRACK and stay there.
    always_comb begin
        w_nextState = ST_DISABLED;
        if (en) begin
            case (r_state)
                ST_DISABLED: w_nextState = ST_PRIME;
                ST_PRIME:    w_nextState = ST_TRACK;
                ST_TRACK:    w_nextState = ST_TRACK;
                default:     w_nextState = ST_DISABLED;
            endcase
        end
    end

    // Sample register, FSM and change-detection reference. last_q follows
    // every capture, including dropped ones, so a dropped value is not
    // retried on the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sq    <= '0;
            r_lastQ <= '0;
            r_state <= ST_DISABLED;
        end else begin
            r_sq    <= out_port;
            r_state <= w_nextState;
            if (w_capture) begin
                r_lastQ <= r_sq;
            end
        end
    end

    // Overflow flag and drop counter. A drop in the same cycle as a clear
    // wins, leaving the flag set and the counter at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_dropCnt  <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            r_dropCnt  <= clr_ovf ? 8'd1 : satInc8(r_dropCnt);
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
            r_dropCnt  <= '0;
        end
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_capture),
        .i_pop   (w_pop),
        .i_data  (r_sq),
        .o_data  (w_headData),
        .o_full  (w_fifoFull),
        .o_empty (w_fifoEmpty),
        .o_count (w_fifoCount)
    );

    assign cap_data  = w_headData;
    assign cap_valid = !w_fifoEmpty;
    assign count     = w_fifoCount;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_dropCnt;

endmodule

// File: tb/tb_out_port_capture.sv
// -----------------------------------------------------------------------------
// tb_out_port_capture
// Purpose : Drives out_port_capture through directed scenarios and a random
//           run, comparing every cycle against a queue-based model.
// -----------------------------------------------------------------------------
module tb_out_port_capture;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          en;
    logic [DW-1:0] outPort;
    logic          clrOvf;
    logic [DW-1:0] capData;
    logic          capValid;
    logic          capReady;
    logic [CW-1:0] count;
    logic          overflow;
    logic [7:0]    dropCnt;

    int errors = 0;
    int checks = 0;

    // Model state: queued words, last captured value, the previous port
    // value, and how many consecutive enabled cycles have elapsed.
    logic [DW-1:0] mFifo[$];
    logic [DW-1:0] mSample;
    logic [DW-1:0] mLast;
    int            enRun;
    logic          mOvf;
    int            mDrop;

    logic [DW-1:0] popLog[$];

    out_port_capture #(
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .out_port  (outPort),
        .clr_ovf   (clrOvf),
        .cap_data  (capData),
        .cap_valid (capValid),
        .cap_ready (capReady),
        .count     (count),
        .overflow  (overflow),
        .drop_cnt  (dropCnt)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model.
    task automatic checkOutput();
        logic [DW-1:0] expData;
        expData = (mFifo.size() > 0) ? mFifo[0] : '0;
        checkValue("cap_valid", 32'(capValid), 32'(mFifo.size() > 0));
        checkValue("cap_data",  32'(capData),  32'(expData));
        checkValue("count",     32'(count),    32'(mFifo.size()));
        checkValue("overflow",  32'(overflow), 32'(mOvf));
        checkValue("drop_cnt",  32'(dropCnt),  32'(mDrop));
    endtask

    // Advance the model by one clock using the inputs that were applied.
    task automatic modelStep(input logic r, input logic e, input logic [DW-1:0] p,
                             input logic c, input logic rdy);
        logic cap;
        logic drop;
        if (r) begin
            mFifo.delete();
            mSample = '0;
            mLast   = '0;
            enRun   = 0;
            mOvf    = 1'b0;
            mDrop   = 0;
        end else begin
            cap  = e && (enRun == 1 || (enRun >= 2 && mSample != mLast));
            drop = 1'b0;
            if (rdy && mFifo.size() > 0) begin
                void'(mFifo.pop_front());
            end
            if (cap) begin
                mLast = mSample;
                if (mFifo.size() < DEPTH) mFifo.push_back(mSample);
                else drop = 1'b1;
            end
            if (drop) begin
                mOvf  = 1'b1;
                mDrop = c ? 1 : ((mDrop < 255) ? mDrop + 1 : 255);
            end else if (c) begin
                mOvf  = 1'b0;
                mDrop = 0;
            end
            enRun   = e ? ((enRun < 2) ? enRun + 1 : 2) : 0;
            mSample = p;
        end
    endtask

    // One clock: drive at the falling edge, step the model on the rising
    // edge, then compare shortly after.
    task automatic applyStimulus(input logic r, input logic e, input logic [DW-1:0] p,
                                 input logic c, input logic rdy);
        @(negedge clk);
        if (!r && rdy && capValid) popLog.push_back(capData);
        rst      = r;
        en       = e;
        outPort  = p;
        clrOvf   = c;
        capReady = rdy;
        @(posedge clk);
        modelStep(r, e, p, c, rdy);
        #1;
        checkOutput();
    endtask

    initial begin
        int cntBefore;
        rst = 1'b1; en = 1'b1; outPort = 16'h1234; clrOvf = 1'b0; capReady = 1'b0;
        mSample = '0; mLast = '0; enRun = 0; mOvf = 1'b0; mDrop = 0;

        // Reset then PRIME capture of the first sampled value.
        applyStimulus(1, 1, 16'h1234, 0, 0);
        applyStimulus(1, 1, 16'h1234, 0, 0);
        checkValue("rst_valid", 32'(capValid), 32'd0);
        checkValue("rst_data",  32'(capData),  32'd0);
        applyStimulus(0, 1, 16'h1234, 0, 0);
        checkValue("prime_early", 32'(capValid), 32'd0);
        applyStimulus(0, 1, 16'h1234, 0, 0);
        checkValue("prime_valid", 32'(capValid), 32'd1);
        checkValue("prime_data",  32'(capData),  32'h1234);
        checkValue("prime_count", 32'(count),    32'd1);

        // Repeated value then a change, consumer always ready.
        popLog.delete();
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 16'hAAAA, 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 16'h5555, 0, 1);
        checkValue("nodup_size", 32'(popLog.size()), 32'd3);
        checkValue("nodup_0", 32'(popLog[0]), 32'h1234);
        checkValue("nodup_1", 32'(popLog[1]), 32'hAAAA);
        checkValue("nodup_2", 32'(popLog[2]), 32'h5555);

        // Fill past capacity with ten distinct values.
        applyStimulus(1, 1, 16'h0000, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, 16'(16'h1000 + i), 0, 0);
        applyStimulus(0, 1, 16'h1009, 0, 0);
        applyStimulus(0, 1, 16'h1009, 0, 0);
        checkValue("full_count", 32'(count),    32'd8);
        checkValue("full_ovf",   32'(overflow), 32'd1);
        checkValue("full_drop",  32'(dropCnt),  32'd2);
        checkValue("full_head",  32'(capData),  32'h1000);

        // Clear coinciding with a drop, then clear on its own.
        applyStimulus(0, 1, 16'h2000, 0, 0);
        applyStimulus(0, 1, 16'h2000, 1, 0);
        checkValue("clrdrop_ovf",  32'(overflow), 32'd1);
        checkValue("clrdrop_cnt",  32'(dropCnt),  32'd1);
        applyStimulus(0, 1, 16'h2000, 1, 0);
        checkValue("clr_ovf",  32'(overflow), 32'd0);
        checkValue("clr_cnt",  32'(dropCnt),  32'd0);

        // Capture into a full FIFO with a simultaneous pop.
        applyStimulus(0, 1, 16'h3000, 0, 0);
        applyStimulus(0, 1, 16'h3000, 0, 1);
        checkValue("fullpop_count", 32'(count),    32'd8);
        checkValue("fullpop_ovf",   32'(overflow), 32'd0);
        checkValue("fullpop_head",  32'(capData),  32'h1001);

        // Drain and confirm ordering.
        popLog.delete();
        for (int i = 0; i < 9; i++) applyStimulus(0, 1, 16'h3000, 0, 1);
        checkValue("drain_size", 32'(popLog.size()), 32'd8);
        for (int i = 0; i < 7; i++) checkValue("drain_order", 32'(popLog[i]), 32'(16'h1001 + i));
        checkValue("drain_last", 32'(popLog[7]), 32'h3000);

        // Enable toggle with a constant port value forces a recapture.
        applyStimulus(0, 1, 16'h00FF, 0, 0);
        applyStimulus(0, 1, 16'h00FF, 0, 0);
        cntBefore = int'(count);
        checkValue("toggle_pre", 32'(cntBefore), 32'd1);
        applyStimulus(0, 0, 16'h00FF, 0, 0);
        applyStimulus(0, 1, 16'h00FF, 0, 0);
        applyStimulus(0, 1, 16'h00FF, 0, 0);
        checkValue("toggle_post", 32'(count), 32'(cntBefore + 1));

        // Reset in the middle of a drain discards everything.
        applyStimulus(0, 1, 16'h00FF, 0, 1);
        applyStimulus(1, 1, 16'h00FF, 1, 1);
        checkValue("midrst_count", 32'(count),    32'd0);
        checkValue("midrst_valid", 32'(capValid), 32'd0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic          r;
            logic          e;
            logic [DW-1:0] p;
            logic          c;
            logic          rdy;
            r   = ($urandom_range(0, 99) == 0);
            e   = ($urandom_range(0, 15) != 0);
            p   = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 3));
            c   = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 2) == 0);
            applyStimulus(r, e, p, c, rdy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/out_port_capture.md
OUT_PORT_CAPTURE -- requirements
Module: out_port_capture

Interface
REQ-001 Parameter DATA_W, default 16, width of the CPU output port and captured words.
REQ-002 Parameter DEPTH, default 8, capture FIFO entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset is synchronous and active-high.
REQ-005 en  input  1  capture enable.
REQ-006 out_port  input  DATA_W  CPU output port value being monitored.
REQ-007 clr_ovf  input  1  one-cycle pulse that clears overflow and drop_cnt.
REQ-008 cap_data  output  DATA_W  oldest captured word at the FIFO head.
REQ-009 cap_valid  output  1  cap_data holds a valid entry.
REQ-010 cap_ready  input  1  consumer accepts the head entry.
REQ-011 count  output  $clog2(DEPTH)+1  number of FIFO entries currently held.
REQ-012 overflow  output  1  sticky flag: a capture was dropped.
REQ-013 drop_cnt  output  8  number of dropped captures, saturating at 255.

Function
REQ-014 Every cycle, out_port shall be registered into sample register s_q; all decisions use s_q, never raw out_port.
REQ-015 The FSM shall have the states DISABLED, PRIME and TRACK.
REQ-016 DISABLED shall go to PRIME when en=1; any state shall go to DISABLED when en=0, with no capture in that cycle.
REQ-017 In PRIME, s_q shall be captured unconditionally, stored in last_q, and the FSM shall go to TRACK.
REQ-018 In TRACK, a capture shall occur only when s_q != last_q, and last_q shall then update to s_q.
REQ-019 Latency: a value stable on out_port before edge k, if captured, shall be in the FIFO and visible on cap_data/cap_valid after edge k+1; there is no bypass path.
REQ-020 Pop: the head entry shall be removed at the edge where cap_valid=1 and cap_ready=1; cap_ready while empty shall have no effect.
REQ-021 cap_data shall stay stable while cap_valid=1 and cap_ready=0.
REQ-022 Full, capture without pop: the word shall be dropped, overflow shall be set, drop_cnt shall increment (saturating), and last_q shall still update.
REQ-023 Full, capture with simultaneous pop: the capture shall be accepted, count shall be unchanged, and there shall be no overflow.
REQ-024 Empty, capture with cap_ready=1: the push shall occur and count shall become 1.
REQ-025 Pointers shall wrap modulo DEPTH; count shall distinguish full (DEPTH) from empty (0).
REQ-026 If clr_ovf and a drop occur in the same cycle, the drop shall win: overflow=1 and drop_cnt=1.
REQ-027 Equal consecutive values in TRACK shall never be captured, for any run length.

Reset
REQ-028 On rst=1 at an edge: FSM=DISABLED, FIFO empty, count=0, cap_valid=0, cap_data=0, s_q=0, last_q=0, overflow=0, drop_cnt=0.
REQ-029 rst shall take priority over en, clr_ovf and cap_ready in the same cycle; a reset mid-stream shall discard all held entries.
REQ-030 After rst is released with en=1, the first s_q value shall be captured via PRIME.

Structure
REQ-031 Package io_pkg shall hold the DATA_W and DEPTH defaults and the FSM state typedef/encoding.
REQ-032 Storage shall be a sub-module sync_fifo (push, pop, full, empty, count, head data); FSM, change detection and overflow logic shall stay in out_port_capture.

Verification
REQ-033 The bench shall drive rst=1 for 2 cycles with en=1 and out_port=16'h1234 -> after release, PRIME captures: cap_valid=1, cap_data=16'h1234, count=1, two edges after the first non-reset edge.
REQ-034 The bench shall drive 16'hAAAA for 5 cycles then 16'h5555 with cap_ready=1 -> exactly two captures, AAAA then 5555, and no duplicates.
REQ-035 The bench shall hold cap_ready=0 and apply 10 distinct values (DEPTH=8) -> count=8, overflow=1, drop_cnt=2, and a drain yields the first 8 values in order.
REQ-036 The bench shall create the full condition, then apply a new value together with cap_ready=1 -> count stays 8, overflow stays 0, and the head advances.
REQ-037 The bench shall pulse clr_ovf in the same cycle as a drop -> overflow=1 and drop_cnt=1; pulsing clr_ovf alone then gives overflow=0 and drop_cnt=0.
REQ-038 The bench shall toggle en 1->0->1 with out_port constant at 16'h00FF -> a recapture of 00FF via PRIME and count incremented by 1; assert rst mid-drain -> count=0 and cap_valid=0 the next cycle.
